// File: rtl/operand_sequencer.sv
// Steps a 4-bit external ripple adder through operand A, operand B, add and show phases from one debounced button.
// Optional OPSEQ_ACCUM_EN: SHOW + press feeds the low nibble of the result back as the next A (running total).
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [4:0] result,
    output logic       valid,
    output logic [1:0] phase
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ADD    = 2'd2,
        SHOW   = 2'd3
    } state_t;

    logic             btn_s1_q, btn_s2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [4:0]       result_q, result_d;
    logic             valid_q, valid_d;

    // Count clocks the synchronized level differs from the accepted one; any agreement restarts the count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        press = 1'b0;
        if (btn_s2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = btn_s2_q;
                press = btn_s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            deb_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
        end
    end

    // ADD ignores press: it always lasts one cycle so the adder settles before capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            LOAD_A: if (press) begin
                a_d     = sw;
                b_d     = 4'd0;
                state_d = LOAD_B;
            end
            LOAD_B: if (press) begin
                b_d     = sw;
                state_d = ADD;
            end
            ADD: begin
                result_d = {cout, sum};
                valid_d  = 1'b1;
                state_d  = SHOW;
            end
            SHOW: if (press) begin
                valid_d = 1'b0;
`ifdef OPSEQ_ACCUM_EN
                a_d     = result_q[3:0];
                b_d     = 4'd0;
                state_d = LOAD_B;
`else
                state_d = LOAD_A;
`endif
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            result_q <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign result = result_q;
    assign valid  = valid_q;
    assign phase  = state_q;

endmodule
